instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, giving the width of the fetch PC in halfword (instruction) units.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  instruction memory read strobe.
- imem_addr  output  PC_W  read address; equals pc.
- imem_rdata  input  16  read data; valid exactly one cycle after imem_req.
- flush  input  1  redirect request from execute (branch/BX).
- flush_pc  input  PC_W  redirect target.
- instruction  output  16  instruction word to the decoder.
- instr_pc  output  PC_W  PC of the presented instruction.
- instr_valid  output  1  instruction/instr_pc are valid.
- instr_ready  input  1  decoder accepts; a transfer occurs when instr_valid & instr_ready.
- pc  output  PC_W  next fetch address.

Function
REQ-004 The block SHALL hold a 2-entry in-order FIFO of {instruction, instr_pc}, and SHALL drive instruction, instr_pc and instr_valid from the FIFO head (instr_valid = not empty).
REQ-005 The state machine SHALL have four states, with transitions:
- BOOT: first cycle after reset release; no request; go to RUN.
- RUN: issue requests; go to FULL when credit is exhausted, or to REDIR on flush.
- FULL: no request; go to RUN when credit frees, or to REDIR on flush.
- REDIR: issue a request at the new pc; go to RUN.
REQ-006 imem_req SHALL be 1 only when (occupancy + outstanding - pop) < 2, where pop = instr_valid & instr_ready; this allows sustained throughput of 1 instruction/cycle.
REQ-007 Each issued request SHALL advance pc by 1, with modulo 2^PC_W wrap-around (all-ones wraps to 0).
REQ-008 The returned imem_rdata SHALL be written to the FIFO tail at the end of the cycle following its request, tagged with the request address, and becomes visible the next cycle.
REQ-009 A simultaneous push and pop SHALL both complete, leaving occupancy unchanged.
REQ-010 On flush, the block SHALL:
- clear the FIFO;
- discard any in-flight response (epoch bit toggled; a response with a stale epoch is dropped);
- load pc <= flush_pc;
- enter REDIR.
REQ-011 instr_valid SHALL be forced to 0 combinationally during a flush cycle; no transfer occurs in that cycle.
REQ-012 flush SHALL take priority over a same-cycle request, push or pop.
REQ-013 A flush in BOOT SHALL load flush_pc and then proceed as REDIR.
REQ-014 instruction order SHALL be preserved, with no duplication or loss, under any pattern of instr_ready.

Reset
REQ-015 While reset=0 the block SHALL hold:
- state=BOOT, FIFO empty, no outstanding request, epoch=0;
- pc=RESET_PC, imem_req=0, instr_valid=0;
- instruction=16'h0000, instr_pc=0.
REQ-016 Assertion of reset mid-operation SHALL force the REQ-015 values immediately (asynchronously) and SHALL drop any in-flight response.

Configuration
REQ-017 With macro IFETCH_BRANCH_PREDECODE_EN defined, the block SHALL predecode each returned word with bits[15:11]=5'b11100 (unconditional B), as follows:
- enqueue 16'hBF00 (NOP) with that word's PC;
- redirect internally as a flush to target = branch_pc + 1 + sign-extended imm11 (modulo 2^PC_W);
- leave the FIFO entries older than the branch intact.
REQ-018 Without IFETCH_BRANCH_PREDECODE_EN, all words SHALL pass through unmodified and only the flush port redirects.

Verification
REQ-019 Release reset with instr_ready=1 and memory returning 16'h1800+addr -> first instr_valid in the 3rd cycle after release with instr_pc=0 and instruction=16'h1800, then one instruction per cycle with consecutive PCs.
REQ-020 Hold instr_ready=0 for 6 cycles mid-stream -> occupancy never exceeds 2 and imem_req=0 while credit is 0; after release, delivery resumes with no PC skipped or repeated.
REQ-021 Pulse flush with flush_pc=16'h0040 while the FIFO is full and a response is in flight -> instr_valid=0 in the flush cycle, the next delivered instr_pc is 16'h0040, and no stale instruction appears.
REQ-022 Set pc to 16'hFFFF -> requests go to 16'hFFFF then 16'h0000.
REQ-023 Assert reset while instr_valid=1 -> all outputs take their REQ-015 values in the same cycle with no clock edge required.
REQ-024 With IFETCH_BRANCH_PREDECODE_EN defined and memory word 16'hE005 at 16'h0010 -> 16'hBF00 is delivered with instr_pc=16'h0010 and the next delivered instr_pc is 16'h0016.
REQ-025 With IFETCH_BRANCH_PREDECODE_EN defined and memory word 16'hE7FE at 16'h0010 -> the next delivered instr_pc is 16'h000F.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited fetch into a 2-entry queue; IFETCH_BRANCH_PREDECODE_EN turns unconditional B into NOP plus redirect
module instr_fetch #(
    parameter int PC_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] pc
);
    typedef enum logic [1:0] {BOOT, RUN, FULL, REDIR} state_t;
    state_t state;
    logic [15:0] fifo_ins [2];
    logic [PC_W-1:0] fifo_pc [2];
    logic rd_ptr, wr_ptr;
    logic [1:0] count;
    logic outstanding, rsp_epoch, epoch;
    logic [PC_W-1:0] rsp_pc, br_pc;
    logic pop, push, live, req_ok, br;

    assign instr_valid = (count != 2'd0) && !flush;
    assign instruction = fifo_ins[rd_ptr];
    assign instr_pc = fifo_pc[rd_ptr];
    assign pop = instr_valid && instr_ready;
    // a response whose epoch predates the last redirect is dropped and holds no credit
    assign live = outstanding && rsp_epoch == epoch;
    assign push = live && !flush;
    assign req_ok = ({1'b0, count} + {2'b0, live} - {2'b0, pop}) < 3'd2;
    assign imem_req = (state == RUN || state == REDIR) && req_ok && !flush;
    assign imem_addr = pc;

`ifdef IFETCH_BRANCH_PREDECODE_EN
    assign br = push && imem_rdata[15:11] == 5'b11100;
    assign br_pc = rsp_pc + PC_W'($signed(imem_rdata[10:0])) + PC_W'(1);
`else
    assign br = 1'b0;
    assign br_pc = rsp_pc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pc <= RESET_PC;
            count <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            outstanding <= 1'b0;
            rsp_epoch <= 1'b0;
            epoch <= 1'b0;
            rsp_pc <= '0;
            fifo_ins <= '{default: '0};
            fifo_pc <= '{default: '0};
        end else begin
            outstanding <= imem_req;
            if (imem_req) begin
                rsp_pc <= pc;
                rsp_epoch <= epoch;
            end
            if (flush) begin
                count <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                epoch <= ~epoch;
                pc <= flush_pc;
                state <= REDIR;
            end else begin
                if (push) begin
                    fifo_ins[wr_ptr] <= br ? 16'hBF00 : imem_rdata;
                    fifo_pc[wr_ptr] <= rsp_pc;
                    wr_ptr <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + 2'(push) - 2'(pop);
                if (br) begin
                    epoch <= ~epoch;
                    pc <= br_pc;
                    state <= REDIR;
                end else begin
                    if (imem_req)
                        pc <= pc + PC_W'(1);
                    state <= (state == BOOT || req_ok) ? RUN : FULL;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus hand-written reset, wrap, redirect and stall sequences
module tb_instr_fetch;
    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, instr_ready = 1'b1;
    logic imem_req, instr_valid;
    logic [15:0] imem_addr, instruction, instr_pc, pc;
    logic [15:0] imem_rdata = 16'h0, flush_pc = 16'h0, br_word = 16'h1810, exp_pc;
    int vectors = 0, errors = 0, xfers = 0;

    typedef struct {
        logic rdy;
        logic fl;
        logic [15:0] fpc;
        logic req;
        logic [15:0] addr;
        logic val;
        logic [15:0] ipc;
    } vec_t;
    vec_t vecs[$];

    instr_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .flush(flush), .flush_pc(flush_pc),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? br_word : 16'h1800 + a;
    endfunction

    always @(posedge clk)
        if (imem_req)
            imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic row(input logic rdy, input logic fl, input logic [15:0] fpc, input logic req,
                       input logic [15:0] addr, input logic val, input logic [15:0] ipc);
        vecs.push_back('{rdy, fl, fpc, req, addr, val, ipc});
    endtask

    task automatic do_flush(input string name, input logic [15:0] target);
        flush = 1'b1;
        flush_pc = target;
        #1;
        check(name, 64'(instr_valid), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
    endtask

    task automatic expect_xfer(input string name, input logic [15:0] epc, input logic [15:0] eins);
        int n = 0;
        while (!(instr_valid && instr_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            vectors++;
            errors++;
            $display("FAIL %s: no transfer within 20 cycles, required pc %h", name, epc);
        end else
            check(name, 64'({instr_pc, instruction}), 64'({epc, eins}));
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_values", 64'({imem_req, instr_valid, instruction, instr_pc, pc, imem_addr}), 64'h0);
        row(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h1, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b1, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h3, 1'b1, 16'h1);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h4, 1'b1, 16'h2);
        for (int i = 0; i < 6; i++)
            row(1'b0, 1'b0, 16'h0, 1'b0, 16'h5, 1'b1, 16'h3);
        row(1'b1, 1'b0, 16'h0, 1'b0, 16'h5, 1'b1, 16'h3);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h5, 1'b1, 16'h4);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h6, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h7, 1'b1, 16'h5);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h8, 1'b1, 16'h6);
        row(1'b1, 1'b1, 16'h0040, 1'b0, 16'h9, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h0040, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h0041, 1'b0, 16'h0);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h0042, 1'b1, 16'h0040);
        row(1'b1, 1'b0, 16'h0, 1'b1, 16'h0043, 1'b1, 16'h0041);
        @(negedge clk);
        reset = 1'b1;
        foreach (vecs[i]) begin
            instr_ready = vecs[i].rdy;
            flush = vecs[i].fl;
            flush_pc = vecs[i].fpc;
            #1;
            check($sformatf("vec%0d", i),
                  64'({imem_req, imem_addr, instr_valid, instr_valid ? instr_pc : 16'h0,
                       instr_valid ? instruction : 16'h0}),
                  64'({vecs[i].req, vecs[i].addr, vecs[i].val, vecs[i].val ? vecs[i].ipc : 16'h0,
                       vecs[i].val ? mem_word(vecs[i].ipc) : 16'h0}));
            @(negedge clk);
        end
        #1;
        check("pre_reset_valid", 64'(instr_valid), 64'h1);
        reset = 1'b0;
        #1;
        check("async_reset", 64'({imem_req, instr_valid, instruction, instr_pc, pc, imem_addr}), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        do_flush("boot_flush", 16'hFFFF);
        check("wrap_req0", 64'({imem_req, imem_addr}), 64'h1FFFF);
        @(negedge clk);
        #1;
        check("wrap_req1", 64'({imem_req, imem_addr}), 64'h10000);
        expect_xfer("wrap_x0", 16'hFFFF, 16'h17FF);
        expect_xfer("wrap_x1", 16'h0000, 16'h1800);
        br_word = 16'hE005;
        do_flush("pd1_flush", 16'h000E);
        expect_xfer("pd1_x0", 16'h000E, 16'h180E);
        expect_xfer("pd1_x1", 16'h000F, 16'h180F);
`ifdef IFETCH_BRANCH_PREDECODE_EN
        expect_xfer("pd1_nop", 16'h0010, 16'hBF00);
        expect_xfer("pd1_target", 16'h0016, 16'h1816);
`else
        expect_xfer("pd1_raw", 16'h0010, 16'hE005);
        expect_xfer("pd1_next", 16'h0011, 16'h1811);
`endif
        br_word = 16'hE7FE;
        do_flush("pd2_flush", 16'h000E);
        expect_xfer("pd2_x0", 16'h000E, 16'h180E);
        expect_xfer("pd2_x1", 16'h000F, 16'h180F);
`ifdef IFETCH_BRANCH_PREDECODE_EN
        expect_xfer("pd2_nop", 16'h0010, 16'hBF00);
        expect_xfer("pd2_target", 16'h000F, 16'h180F);
`else
        expect_xfer("pd2_raw", 16'h0010, 16'hE7FE);
        expect_xfer("pd2_next", 16'h0011, 16'h1811);
`endif
        br_word = 16'h1810;
        do_flush("rnd_flush", 16'h0100);
        exp_pc = 16'h0100;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            instr_ready = 1'($urandom_range(0, 1));
            #1;
            if (instr_valid && instr_ready) begin
                check("rnd_order", 64'({instr_pc, instruction}), 64'({exp_pc, mem_word(exp_pc)}));
                exp_pc = exp_pc + 16'h1;
                xfers++;
            end
        end
        check("rnd_progress", 64'(xfers > 50), 64'h1);
        instr_ready = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
